// File: rtl/op_datapath_if.sv
// Operand-bus / result-FIFO signal bundle between the sequencing side and op_datapath.
`timescale 1ns/1ps
interface op_datapath_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   din;
    logic [2:0]         capture;
    logic               op;
    logic               valid;
    logic [2*WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [CW-1:0]      count;
    logic               overflow;

    modport master (
        output din, capture, op, valid, out_ready,
        input  out_data, out_valid, count, overflow
    );

    modport slave (
        input  din, capture, op, valid, out_ready,
        output out_data, out_valid, count, overflow
    );
endinterface

// File: rtl/op_datapath.sv
// Latches A/B/C from a shared bus, computes A*B+C on op, and queues results
// in a small circular FIFO drained by a ready/valid consumer.
`timescale 1ns/1ps
module op_datapath #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic         clock,
    input logic         rst,
    op_datapath_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0]   a_q, b_q, c_q;
    logic [2*WIDTH-1:0] r_q;
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               overflow_q;
    logic               empty, full, pop, push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = !empty && bus.out_ready;
        push  = bus.valid && (!full || pop);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            r_q <= '0;
        end else begin
            if (bus.capture[0]) a_q <= bus.din;
            if (bus.capture[1]) b_q <= bus.din;
            if (bus.capture[2]) c_q <= bus.din;
            // Operands are zero-extended first, so the product and sum never truncate.
            if (bus.op)
                r_q <= ({{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q}) + {{WIDTH{1'b0}}, c_q};
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (bus.valid && !push) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= r_q;
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.count     = wr_ptr - rd_ptr;
    assign bus.overflow  = overflow_q;
endmodule
